softmax_stable: RTL and testbench

Parametrised, numerically stable softmax engine for the classifier output stage. Accepts one vector of N signed fixed-point logits through a valid/ready handshake, subtracts the vector maximum, and computes exp through an internal LUT. It normalises by a serially computed reciprocal of the exponent sum and returns N Q1.15 probabilities plus the argmax index. It sits between the final dense layer and the result/readout logic, and replaces the fixed 10-class softmax.

---
 rtl/softmax_pkg.sv | 24 ++
 rtl/softmax_exp_lut.sv | 44 ++++
 rtl/softmax_stable.sv | 273 +++++++++++++++++++++++++++
 tb/tb_softmax_stable.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared state encoding, Q-format widths and sizing helpers
// for the softmax_stable engine.
package softmax_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX,
        S_EXP,
        S_DIV,
        S_NORM,
        S_DONE
    } state_e;

    localparam int LOGIT_FRAC = 8;   // fractional bits of the Q8.8 logits
    localparam int PROB_W     = 16;  // unsigned Q1.15 probability width
    localparam int EXP_W      = 16;  // exp LUT output width
    localparam int DIV_BITS   = 32;  // reciprocal numerator is 2^(DIV_BITS-1)

    // Exponent sum width: N values of up to 0xFFFF each
    function automatic int sum_width(input int n);
        return EXP_W + $clog2(n);
    endfunction

endpackage

// File: rtl/softmax_exp_lut.sv
// softmax_exp_lut: registered exp(-d) table, LUT[a] = round(65535*exp(-a*2^EXP_SHIFT/256)).
// Table contents are computed at elaboration; read latency is one cycle.
module softmax_exp_lut
    import softmax_pkg::*;
#(
    parameter int EXP_AW    = 10,
    parameter int EXP_SHIFT = 3
) (
    input  logic              clk,
    input  logic [EXP_AW-1:0] addr,
    output logic [EXP_W-1:0]  data
);

    localparam int DEPTH = 1 << EXP_AW;

    function automatic logic [EXP_W-1:0] lut_val(input int a);
        real y;
        real v;
        y = real'(a) * real'(1 << EXP_SHIFT) / real'(1 << LOGIT_FRAC);
        v = real'((1 << EXP_W) - 1) * $exp(-y) + 0.5;
        return EXP_W'($rtoi(v));
    endfunction

    logic [EXP_W-1:0] rom [DEPTH];
    logic [EXP_W-1:0] data_d;
    logic [EXP_W-1:0] data_q;

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = lut_val(a);
    end

    // Table lookup for the registered read
    always_comb begin
        data_d = rom[addr];
    end

    // One-cycle read register
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/softmax_stable.sv
// softmax_stable: max-subtracted softmax over N_CLASSES Q8.8 logits, producing
// Q1.15 probabilities through an exp LUT and a serial reciprocal of the sum.
// Optional feature macro: SOFTMAX_ARGMAX_EN (argmax index output; constant 0 otherwise).
module softmax_stable
    import softmax_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int DW        = 16,
    parameter int EXP_AW    = 10,
    parameter int EXP_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_CLASSES*DW-1:0]      in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_CLASSES*PROB_W-1:0]  out_data,
    output logic [$clog2(N_CLASSES)-1:0] out_argmax,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_CLASSES);
    localparam int SUM_W = sum_width(N_CLASSES);
    localparam int R_W   = PROB_W + 1;   // reciprocal plus guard bit (R <= 0x8000)
    localparam int CNT_W = ($clog2(N_CLASSES + 1) > $clog2(DIV_BITS)) ?
                           $clog2(N_CLASSES + 1) : $clog2(DIV_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CLASSES - 1);
    localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N_CLASSES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_BITS - 1);
    localparam logic [DW:0]      ADDR_MAX = (DW + 1)'((1 << EXP_AW) - 1);

    // Control state
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // Datapath state
    logic [N_CLASSES*DW-1:0] logits_q, logits_d;
    logic signed [DW-1:0]    max_q, max_d;
    logic [EXP_W-1:0]        e_q [N_CLASSES];
    logic [EXP_W-1:0]        e_d [N_CLASSES];
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [SUM_W-1:0]        rem_q, rem_d;
    logic [R_W-1:0]          quo_q, quo_d;
    logic [PROB_W-1:0]       p_q [N_CLASSES];
    logic [PROB_W-1:0]       p_d [N_CLASSES];

    // Combinational helpers
    logic signed [DW-1:0] x_arr [N_CLASSES];
    logic signed [DW-1:0] x_cur;
    logic [IDX_W-1:0]     sel;
    logic [CNT_W-1:0]     cnt_m1;
    logic [IDX_W-1:0]     wr_idx;
    logic [DW:0]          diff;
    logic [DW:0]          shifted;
    logic [EXP_AW-1:0]    lut_addr;
    logic [EXP_W-1:0]     lut_data;
    logic [SUM_W:0]       rem_shift;
    logic [SUM_W:0]       rem_sub;
    logic                 q_bit;
    logic [PROB_W-1:0]    p_cur;

    for (genvar i = 0; i < N_CLASSES; i++) begin : g_vec
        assign x_arr[i] = logits_q[i*DW +: DW];
        assign out_data[i*PROB_W +: PROB_W] = p_q[i];
    end

    softmax_exp_lut #(
        .EXP_AW    (EXP_AW),
        .EXP_SHIFT (EXP_SHIFT)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .data (lut_data)
    );

    // Element selection, LUT addressing, divider step and normalisation product
    always_comb begin
        sel       = (cnt_q < CNT_N) ? cnt_q[IDX_W-1:0] : '0;
        cnt_m1    = cnt_q - CNT_W'(1);
        wr_idx    = cnt_m1[IDX_W-1:0];
        x_cur     = x_arr[sel];
        // max - x is never negative, so one extra bit holds it unsigned
        diff      = {max_q[DW-1], max_q} - {x_cur[DW-1], x_cur};
        shifted   = diff >> EXP_SHIFT;
        lut_addr  = (shifted > ADDR_MAX) ? ADDR_MAX[EXP_AW-1:0] : shifted[EXP_AW-1:0];
        // Numerator 2^31 has a single 1 in its first (MSB) step
        rem_shift = {rem_q, (cnt_q == '0)};
        rem_sub   = rem_shift - {1'b0, sum_q};
        q_bit     = (rem_shift >= {1'b0, sum_q});
        p_cur     = PROB_W'(({{R_W{1'b0}}, e_q[sel]} * {{EXP_W{1'b0}}, quo_q}) >> PROB_W);
    end

    // Next-state values for the datapath registers in each phase
    always_comb begin
        logits_d = logits_q;
        max_d    = max_q;
        e_d      = e_q;
        sum_d    = sum_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        p_d      = p_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    logits_d = in_data;
                    sum_d    = '0;
                end
            end
            S_MAX: begin
                // Strict greater-than keeps the lowest index on ties
                if (cnt_q == '0 || x_cur > max_q) begin
                    max_d = x_cur;
                end
            end
            S_EXP: begin
                // LUT data lags the address by one cycle
                if (cnt_q != '0) begin
                    e_d[wr_idx] = lut_data;
                    sum_d       = sum_q + SUM_W'(lut_data);
                end
                if (cnt_q == CNT_N) begin
                    rem_d = '0;
                    quo_d = '0;
                end
            end
            S_DIV: begin
                rem_d = q_bit ? rem_sub[SUM_W-1:0] : rem_shift[SUM_W-1:0];
                quo_d = {quo_q[R_W-2:0], q_bit};
            end
            S_NORM: begin
                p_d[sel] = p_cur;
            end
            default: begin
            end
        endcase
    end

    // Sequence the phases and drive the registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= S_MAX;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_MAX: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_EXP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_EXP: begin
                    if (cnt_q == CNT_N) begin
                        state_q <= S_DIV;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (cnt_q == CNT_DIV) begin
                        state_q <= S_NORM;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_NORM: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= S_DONE;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator, divider and result registers; cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            for (int i = 0; i < N_CLASSES; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            sum_q <= sum_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            p_q   <= p_d;
        end
    end

    // Working copies of the logits, running maximum and exponents
    always_ff @(posedge clk) begin
        logits_q <= logits_d;
        max_q    <= max_d;
        e_q      <= e_d;
    end

`ifdef SOFTMAX_ARGMAX_EN
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] argmax_q, argmax_d;

    // Track the running-maximum position and publish it as DONE is entered
    always_comb begin
        idx_d    = idx_q;
        argmax_d = argmax_q;
        if (state_q == S_MAX && (cnt_q == '0 || x_cur > max_q)) begin
            idx_d = sel;
        end
        if (state_q == S_NORM && cnt_q == CNT_LAST) begin
            argmax_d = idx_q;
        end
    end

    // Argmax register is cleared on reset; the scan index is not
    always_ff @(posedge clk) begin
        if (rst) begin
            argmax_q <= '0;
        end else begin
            argmax_q <= argmax_d;
        end
        idx_q <= idx_d;
    end

    assign out_argmax = argmax_q;
`else
    assign out_argmax = '0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_softmax_stable.sv
// tb_softmax_stable: scoreboard bench for softmax_stable with a plain-arithmetic
// softmax reference model, directed corner vectors and random vectors.
`timescale 1ns/1ps
module tb_softmax_stable;

    localparam int N       = 10;
    localparam int DW      = 16;
    localparam int EXP_AW  = 10;
    localparam int EXP_SH  = 3;
    localparam int IW      = $clog2(N);
    localparam int LAT     = 3 * N + 33;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*16-1:0]   out_data;
    logic [IW-1:0]     out_argmax;
    logic              busy;

    always #5 clk = ~clk;

    softmax_stable #(
        .N_CLASSES (N),
        .DW        (DW),
        .EXP_AW    (EXP_AW),
        .EXP_SHIFT (EXP_SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_argmax (out_argmax),
        .busy       (busy)
    );

    typedef struct {
        logic [N*16-1:0] probs;
        int              am;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   lut [1 << EXP_AW];
    int   checks = 0;
    int   passed = 0;
    int   ncyc   = 0;
    int   hs_cyc = -1;
    logic ov_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    // Reference softmax straight from the arithmetic rules
    function automatic exp_t model(input logic [N*DW-1:0] v);
        exp_t                 r;
        int                   x [N];
        longint               e [N];
        int                   mx, mi, d, a;
        longint               s, rc;
        logic signed [DW-1:0] t;
        for (int i = 0; i < N; i++) begin
            t    = v[i*DW +: DW];
            x[i] = int'(t);
        end
        mx = x[0];
        mi = 0;
        for (int i = 1; i < N; i++) begin
            if (x[i] > mx) begin
                mx = x[i];
                mi = i;
            end
        end
        s = 0;
        for (int i = 0; i < N; i++) begin
            d = mx - x[i];
            a = d >> EXP_SH;
            if (a > (1 << EXP_AW) - 1) a = (1 << EXP_AW) - 1;
            e[i] = lut[a];
            s += e[i];
        end
        rc = (64'd1 << 31) / s;
        for (int i = 0; i < N; i++) begin
            r.probs[i*16 +: 16] = 16'((e[i] * rc) >> 16);
        end
`ifdef SOFTMAX_ARGMAX_EN
        r.am = mi;
`else
        r.am = 0;
`endif
        return r;
    endfunction

    // Monitor: latency of each accepted vector and result comparison at handshake
    always @(negedge clk) begin
        exp_t ex;
        int   a;
        ncyc++;
        if (!rst) begin
            if (in_valid && in_ready) acc_q.push_back(ncyc);
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) check("latency_no_accept", 0, 1);
                else begin
                    a = acc_q.pop_front();
                    check("latency", ncyc - a - 1, LAT);
                end
            end
            if (out_valid && out_ready) begin
                hs_cyc = ncyc;
                if (sb.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    ex = sb.pop_front();
                    for (int i = 0; i < N; i++)
                        check($sformatf("p%0d", i), out_data[i*16 +: 16], ex.probs[i*16 +: 16]);
                    check("argmax", out_argmax, ex.am);
                end
            end
        end
        ov_prev = out_valid;
    end

    // Present a vector until accepted; called just after a rising edge
    task automatic send(input logic [N*DW-1:0] v, output int acc_cyc);
        bit ok = 0;
        acc_cyc  = -1;
        in_data  = v;
        in_valid = 1'b1;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                ok      = 1;
                acc_cyc = ncyc;
                sb.push_back(model(v));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] val);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = val;
        return v;
    endfunction

    initial begin
        logic [N*DW-1:0] v;
        logic [N*16-1:0] cap_d;
        logic [IW-1:0]   cap_a;
        int              acc, k;

        for (int a = 0; a < (1 << EXP_AW); a++)
            lut[a] = $rtoi(65535.0 * $exp(-real'(a) * real'(1 << EXP_SH) / 256.0) + 0.5);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data_zero", (out_data == '0), 1);
        check("rst_argmax", out_argmax, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        send('0, acc);
        v = fill(16'h8000); v[3*DW +: DW] = 16'h7FFF;
        send(v, acc);
        v = fill(16'h8000); v[2*DW +: DW] = 16'h0100; v[7*DW +: DW] = 16'h0100;
        send(v, acc);
        wait_drain();

        // Result held while the consumer stalls; busy input ignored
        out_ready = 1'b0;
        v = fill(16'h8000); v[3*DW +: DW] = 16'h7FFF;
        send(v, acc);
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) check("stall_wait_timeout", 0, 1);
        cap_d = out_data;
        cap_a = out_argmax;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = fill(16'h1234);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_data_stable", (out_data == cap_d), 1);
            check("stall_argmax_stable", out_argmax, cap_a);
            check("stall_in_ready", in_ready, 0);
            check("stall_busy", busy, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        v = '0; v[5*DW +: DW] = 16'h0080; v[1*DW +: DW] = 16'hFF00;
        send(v, acc);
        check("accept_after_handshake", acc - hs_cyc, 1);
        wait_drain();

        // Reset in the middle of a vector
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = 16'($urandom_range(0, 2047)) - 16'd1024;
        send(v, acc);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        acc_q.delete();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send('0, acc);
        wait_drain();

        // Random vectors: narrow-range (rich exponents) and full-range logits
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 2 == 0) v[i*DW +: DW] = 16'($urandom_range(0, 2047)) - 16'd1024;
                else            v[i*DW +: DW] = 16'($urandom);
            end
            if (t == 4) v[6*DW +: DW] = v[1*DW +: DW];
            send(v, acc);
        end
        wait_drain();

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
